// File: rtl/rubiks_executor_movimento_if.sv
// Handshake and motor-drive bundle between the robot control unit and the
// face-move executor.
interface rubiks_executor_movimento_if;
  logic       aciona_movimento;
  logic [4:0] codigo_movimento;
  logic [5:0] step;
  logic       dir;
  logic [5:0] en_n;
  logic       fim_movimento;
  logic       ocupado;
  logic       erro_codigo;
  logic [3:0] db_estado;

  modport master (
    output aciona_movimento, codigo_movimento,
    input  step, dir, en_n, fim_movimento, ocupado, erro_codigo, db_estado
  );

  modport slave (
    input  aciona_movimento, codigo_movimento,
    output step, dir, en_n, fim_movimento, ocupado, erro_codigo, db_estado
  );
endinterface

// File: rtl/rubiks_executor_movimento.sv
// Turns a move code into step/dir pulses for one of six face steppers and
// answers with a one-cycle completion strobe after the settle pause.
module rubiks_executor_movimento #(
  parameter int PASSOS_QUARTO = 50,
  parameter int MEIO_PERIODO  = 25000,
  parameter int PAUSA         = 2500000
) (
  input logic                           clock,
  input logic                           reset,
  rubiks_executor_movimento_if.slave    bus
);
  localparam int MAX_CONT = (MEIO_PERIODO > PAUSA) ? MEIO_PERIODO : PAUSA;
  localparam int CW = $clog2(MAX_CONT + 1);
  localparam int SW = $clog2(2 * PASSOS_QUARTO + 1);

  localparam logic [CW-1:0] MEIO_FIM  = CW'(MEIO_PERIODO - 1);
  localparam logic [CW-1:0] PAUSA_FIM = CW'((PAUSA > 0) ? PAUSA - 1 : 0);
  localparam logic [CW-1:0] CONT_UM   = CW'(1);
  localparam logic [SW-1:0] PASSO_UM  = SW'(1);
  localparam logic [SW-1:0] N_QUARTO  = SW'(PASSOS_QUARTO);
  localparam logic [SW-1:0] N_MEIA    = SW'(2 * PASSOS_QUARTO);

  localparam logic [3:0] OCIOSO        = 4'b0000;
  localparam logic [3:0] CARREGA       = 4'b0001;
  localparam logic [3:0] PULSO_ALTO    = 4'b0010;
  localparam logic [3:0] PULSO_BAIXO   = 4'b0011;
  localparam logic [3:0] ASSENTA       = 4'b0100;
  localparam logic [3:0] CONCLUI       = 4'b0101;
  localparam logic [3:0] ESPERA_LIBERA = 4'b0110;

  logic [3:0]    estado, prox_estado;
  logic [CW-1:0] cont, prox_cont;
  logic [SW-1:0] passos, prox_passos;
  logic [SW-1:0] total_passos;
  logic [4:0]    codigo;
  logic [5:0]    step_q, en_n_q;
  logic          dir_q, fim_q, ocupado_q, erro_q;
  logic          aceita;

  function automatic logic [5:0] face_onehot(input logic [2:0] face);
    logic [5:0] oh;
    case (face)
      3'd0:    oh = 6'b000001;
      3'd1:    oh = 6'b000010;
      3'd2:    oh = 6'b000100;
      3'd3:    oh = 6'b001000;
      3'd4:    oh = 6'b010000;
      3'd5:    oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

  assign aceita = (estado == OCIOSO) && bus.aciona_movimento;

  always_comb begin
    prox_estado = estado;
    prox_cont   = cont;
    prox_passos = passos;
    case (estado)
      OCIOSO: begin
        prox_cont   = '0;
        prox_passos = '0;
        if (bus.aciona_movimento) prox_estado = CARREGA;
        else                      prox_estado = OCIOSO;
      end
      CARREGA: begin
        prox_cont   = '0;
        prox_passos = '0;
        if (codigo[2:1] == 2'b11 || codigo[4:3] == 2'b11) prox_estado = CONCLUI;
        else                                              prox_estado = PULSO_ALTO;
      end
      PULSO_ALTO: begin
        if (cont == MEIO_FIM) begin
          prox_cont   = '0;
          prox_estado = PULSO_BAIXO;
        end else begin
          prox_cont = cont + CONT_UM;
        end
      end
      PULSO_BAIXO: begin
        if (cont == MEIO_FIM) begin
          prox_cont   = '0;
          prox_passos = passos + PASSO_UM;
          if (prox_passos == total_passos) prox_estado = (PAUSA == 0) ? CONCLUI : ASSENTA;
          else                             prox_estado = PULSO_ALTO;
        end else begin
          prox_cont = cont + CONT_UM;
        end
      end
      ASSENTA: begin
        if (cont == PAUSA_FIM) begin
          prox_cont   = '0;
          prox_estado = CONCLUI;
        end else begin
          prox_cont = cont + CONT_UM;
        end
      end
      CONCLUI, ESPERA_LIBERA: begin
        if (bus.aciona_movimento) prox_estado = ESPERA_LIBERA;
        else                      prox_estado = OCIOSO;
      end
      default: begin
        prox_estado = OCIOSO;
        prox_cont   = '0;
        prox_passos = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so each one is valid for the whole state cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      cont         <= '0;
      passos       <= '0;
      total_passos <= '0;
      codigo       <= 5'b00000;
      step_q       <= 6'b000000;
      dir_q        <= 1'b0;
      en_n_q       <= 6'b111111;
      fim_q        <= 1'b0;
      ocupado_q    <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      estado    <= prox_estado;
      cont      <= prox_cont;
      passos    <= prox_passos;
      fim_q     <= (prox_estado == CONCLUI);
      ocupado_q <= (prox_estado != OCIOSO);
      erro_q    <= aceita && (bus.codigo_movimento[2:1] == 2'b11);
      step_q    <= (prox_estado == PULSO_ALTO) ? face_onehot(codigo[2:0]) : 6'b000000;
      if (aceita) begin
        codigo       <= bus.codigo_movimento;
        dir_q        <= ~bus.codigo_movimento[3];
        total_passos <= (bus.codigo_movimento[4:3] == 2'b10) ? N_MEIA : N_QUARTO;
      end else begin
        codigo       <= codigo;
        dir_q        <= dir_q;
        total_passos <= total_passos;
      end
      // Driver enable opens with the accepted move and closes as the move concludes.
      if (aceita && bus.codigo_movimento[4:3] != 2'b11)
        en_n_q <= ~face_onehot(bus.codigo_movimento[2:0]);
      else if (prox_estado == CONCLUI || prox_estado == OCIOSO)
        en_n_q <= 6'b111111;
      else
        en_n_q <= en_n_q;
    end
  end

  assign bus.step          = step_q;
  assign bus.dir           = dir_q;
  assign bus.en_n          = en_n_q;
  assign bus.fim_movimento = fim_q;
  assign bus.ocupado       = ocupado_q;
  assign bus.erro_codigo   = erro_q;
  assign bus.db_estado     = estado;
endmodule

// File: tb/tb_rubiks_executor_movimento.sv
// Randomized and directed moves checked against a per-move timing model.
module tb_rubiks_executor_movimento;
  localparam int PQ = 4;
  localparam int MP = 2;
  localparam int PA = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  rubiks_executor_movimento_if bus_if ();

  rubiks_executor_movimento #(
    .PASSOS_QUARTO(PQ), .MEIO_PERIODO(MP), .PAUSA(PA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_move(input logic [4:0] cod, input int hold_extra, input bit drop_mid,
                          input logic [4:0] cod_change, input string tag);
    int n, lat, face, tipo, fim_cnt, fim_at, err_cnt, err_at;
    int step_bad, en_bad, dir_bad, pulses, hold_bad, k;
    logic [5:0] oh, exp_en, exp_step;
    logic exp_dir, prev;
    face = int'(cod[2:0]);
    tipo = int'(cod[4:3]);
    n = (face > 5 || tipo == 3) ? 0 : ((tipo == 2) ? 2 * PQ : PQ);
    lat = (n == 0) ? 1 : 1 + n * 2 * MP + PA;
    oh = (face < 6) ? 6'(1 << face) : 6'b000000;
    exp_en = (n > 0) ? ~oh : 6'b111111;
    exp_dir = ~cod[3];
    fim_cnt = 0; fim_at = -1; err_cnt = 0; err_at = -1;
    step_bad = 0; en_bad = 0; dir_bad = 0; pulses = 0; hold_bad = 0; prev = 1'b0;

    @(negedge clock);
    bus_if.codigo_movimento = cod;
    bus_if.aciona_movimento = 1'b1;
    @(posedge clock); #1;
    check_val({tag, " carrega"}, 32'(bus_if.db_estado), 32'd1);

    for (int c = 0; c <= lat + 2; c++) begin
      exp_step = (c >= 1 && c <= n * 2 * MP && ((c - 1) / MP) % 2 == 0) ? oh : 6'b000000;
      if (bus_if.step !== exp_step) step_bad++;
      if (((bus_if.step & oh) != 6'b000000) && !prev) pulses++;
      prev = ((bus_if.step & oh) != 6'b000000);
      if (c < lat && bus_if.en_n !== exp_en) en_bad++;
      if (c > lat && bus_if.en_n !== 6'b111111) en_bad++;
      if (c <= lat && bus_if.dir !== exp_dir) dir_bad++;
      if (bus_if.fim_movimento === 1'b1) begin fim_cnt++; fim_at = c; end
      if (bus_if.erro_codigo === 1'b1) begin err_cnt++; err_at = c; end
      if (c == 2) begin
        bus_if.codigo_movimento = cod_change;
        if (drop_mid) bus_if.aciona_movimento = 1'b0;
      end
      @(posedge clock); #1;
    end

    check_val({tag, " fim count"}, 32'(fim_cnt), 32'd1);
    check_val({tag, " fim cycle"}, 32'(fim_at), 32'(lat));
    check_val({tag, " erro count"}, 32'(err_cnt), (face > 5) ? 32'd1 : 32'd0);
    if (face > 5) check_val({tag, " erro cycle"}, 32'(err_at), 32'd0);
    check_val({tag, " step pattern errs"}, 32'(step_bad), 32'd0);
    check_val({tag, " pulses"}, 32'(pulses), 32'(n));
    check_val({tag, " en_n errs"}, 32'(en_bad), 32'd0);
    check_val({tag, " dir errs"}, 32'(dir_bad), 32'd0);

    if (bus_if.aciona_movimento) begin
      for (int h = 0; h < hold_extra; h++) begin
        if (bus_if.db_estado !== 4'd6 || bus_if.step !== 6'b000000 || bus_if.fim_movimento !== 1'b0)
          hold_bad++;
        @(posedge clock); #1;
      end
      if (hold_extra > 0) check_val({tag, " espera hold errs"}, 32'(hold_bad), 32'd0);
      bus_if.aciona_movimento = 1'b0;
    end
    k = 0;
    while (bus_if.db_estado !== 4'd0 && k < 10) begin
      @(posedge clock); #1;
      k++;
    end
    check_val({tag, " ocioso"}, 32'(bus_if.db_estado), 32'd0);
    check_val({tag, " ocupado idle"}, 32'(bus_if.ocupado), 32'd0);
  endtask

  initial begin
    int fim_seen;
    logic [4:0] rc;
    bus_if.aciona_movimento = 1'b0;
    bus_if.codigo_movimento = 5'b00000;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst step", 32'(bus_if.step), 32'd0);
    check_val("rst en_n", 32'(bus_if.en_n), 32'h3f);
    check_val("rst dir", 32'(bus_if.dir), 32'd0);
    check_val("rst fim", 32'(bus_if.fim_movimento), 32'd0);
    check_val("rst ocupado", 32'(bus_if.ocupado), 32'd0);
    check_val("rst erro", 32'(bus_if.erro_codigo), 32'd0);
    check_val("rst estado", 32'(bus_if.db_estado), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    run_move(5'b00_010, 5, 1'b0, 5'b00_010, "F cw");
    run_move(5'b10_101, 0, 1'b0, 5'b10_101, "R half");
    run_move(5'b01_000, 0, 1'b1, 5'b00_011, "U ccw drop");
    run_move(5'b00_111, 0, 1'b0, 5'b00_111, "face7");
    run_move(5'b11_001, 2, 1'b0, 5'b11_001, "noop");

    for (int i = 0; i < 10; i++) begin
      rc = 5'($urandom_range(0, 31));
      run_move(rc, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 5'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset lands during the third high phase of a quarter turn.
    @(negedge clock);
    bus_if.codigo_movimento = 5'b00_010;
    bus_if.aciona_movimento = 1'b1;
    @(posedge clock); #1;
    repeat (9) begin @(posedge clock); #1; end
    check_val("pre-reset step high", 32'(bus_if.step), 32'h04);
    reset = 1'b1;
    bus_if.aciona_movimento = 1'b0;
    @(posedge clock); #1;
    check_val("abort step", 32'(bus_if.step), 32'd0);
    check_val("abort en_n", 32'(bus_if.en_n), 32'h3f);
    check_val("abort estado", 32'(bus_if.db_estado), 32'd0);
    check_val("abort ocupado", 32'(bus_if.ocupado), 32'd0);
    fim_seen = (bus_if.fim_movimento === 1'b1) ? 1 : 0;
    reset = 1'b0;
    repeat (30) begin
      @(posedge clock); #1;
      if (bus_if.fim_movimento === 1'b1) fim_seen++;
    end
    check_val("abort no fim", 32'(fim_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
